// File: rtl/mask_rr_arb_pkg.sv
// Shared types and helpers for the mask_rr_arb round-robin arbiter.
package mask_rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Width of a binary requester index; never narrower than one bit.
  function automatic int idx_w(input int w);
    if (w <= 1) begin
      return 1;
    end else begin
      return $clog2(w);
    end
  endfunction

endpackage

// File: rtl/mask_rr_arb_if.sv
// Request/grant bundle of mask_rr_arb. o_gnt_cnt exists only when
// MASK_RR_ARB_PERF_EN is defined.
interface mask_rr_arb_if
  import mask_rr_arb_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  localparam int IDX_W = idx_w(W);

  logic [W-1:0]     i_req;
  logic             i_last;
  logic             i_ack;
  logic [W-1:0]     o_gnt;
  logic             o_gnt_vld;
  logic [IDX_W-1:0] o_gnt_idx;
`ifdef MASK_RR_ARB_PERF_EN
  logic [W*CNT_W-1:0] o_gnt_cnt;
`endif

  // Arbiter side: takes requests/acks, drives grants.
  modport master (
    input  i_req, i_last, i_ack,
    output o_gnt, o_gnt_vld, o_gnt_idx
`ifdef MASK_RR_ARB_PERF_EN
    , output o_gnt_cnt
`endif
  );

  // Requester/downstream side.
  modport slave (
    output i_req, i_last, i_ack,
    input  o_gnt, o_gnt_vld, o_gnt_idx
`ifdef MASK_RR_ARB_PERF_EN
    , input o_gnt_cnt
`endif
  );

endinterface

// File: rtl/mask_rr_arb_chk.sv
// Protocol and structural checks for mask_rr_arb (simulation only effect).
module mask_rr_arb_chk #(
  parameter int W = 8
) (
  input logic         clk,
  input logic         arst_n,
  input logic [W-1:0] req,
  input logic [W-1:0] gnt,
  input logic         gnt_vld
);

  // A granted requester must keep its request up until the grant is acked.
  a_req_held: assert property (@(posedge clk) disable iff (!arst_n)
    gnt_vld |-> |(req & gnt));

  // The grant is one-hot or empty.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!arst_n)
    $onehot0(gnt));

  // Valid mirrors a non-empty grant.
  a_vld_match: assert property (@(posedge clk) disable iff (!arst_n)
    gnt_vld == (|gnt));

endmodule

// File: rtl/mask_rr_arb_ffs_lsb.sv
// Lowest-set-bit picker: one-hot of the lowest set bit of vec plus its
// binary index. An all-zero vec yields oh = 0 and idx = 0.
module ffs_lsb
  import mask_rr_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]        vec,
  output logic [W-1:0]        oh,
  output logic [idx_w(W)-1:0] idx
);
  localparam int IDX_W = idx_w(W);

  // Scan from LSB upward; the first set bit wins.
  always_comb begin
    logic found_s;
    found_s = 1'b0;
    oh      = {W{1'b0}};
    idx     = {IDX_W{1'b0}};
    for (int i = 0; i < W; i++) begin
      if (vec[i] && !found_s) begin
        oh[i] = 1'b1;
        idx   = IDX_W'(i);
      end else begin
        oh[i] = 1'b0;
      end
      found_s = found_s | vec[i];
    end
  end

endmodule

// File: rtl/mask_rr_arb.sv
// mask_rr_arb: registered round-robin arbiter with valid/ack handshake and
// optional packet lock (LOCK). Priority rotates via a unary mask built from
// the one-hot last-winner pointer. Define MASK_RR_ARB_PERF_EN to add
// saturating per-requester accepted-grant counters on o_gnt_cnt.
module mask_rr_arb
  import mask_rr_arb_pkg::*;
#(
  parameter int   W     = 8,
  parameter logic LOCK  = 1'b1,
  parameter int   CNT_W = 16
) (
  input logic           clk,
  input logic           arst_n,
  mask_rr_arb_if.master bus
);
  localparam int IDX_W = idx_w(W);
  localparam logic [W-1:0] PTR_RST = W'(1'b1) << (W - 1);

  arb_state_e       state_r, state_nxt_s;
  logic [W-1:0]     gnt_r, gnt_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic             vld_r;
  logic [W-1:0]     ptr_r, ptr_nxt_s;
  logic             busy_s;
  logic [W-1:0]     base_s, req_s, mask_s, cand_s;
  logic [W-1:0]     cand_oh_s, wrap_oh_s, win_oh_s;
  logic [IDX_W-1:0] cand_idx_s, wrap_idx_s, win_idx_s;

  assign busy_s = (state_r != IDLE);

  // While a grant is live, re-arbitration uses the current grant as the
  // new pointer and excludes the acked requester; it is re-admitted only
  // after a pass through IDLE, which gives the sole-requester bubble.
  always_comb begin
    logic run_s;
    if (busy_s) begin
      base_s = gnt_r;
      req_s  = bus.i_req & ~gnt_r;
    end else begin
      base_s = ptr_r;
      req_s  = bus.i_req;
    end
    run_s = 1'b0;
    for (int j = 0; j < W; j++) begin
      mask_s[j] = run_s;
      run_s     = run_s | base_s[j];
    end
    cand_s = req_s & mask_s;
  end

  ffs_lsb #(.W(W)) u_ffs_cand (
    .vec (cand_s),
    .oh  (cand_oh_s),
    .idx (cand_idx_s)
  );

  ffs_lsb #(.W(W)) u_ffs_wrap (
    .vec (req_s),
    .oh  (wrap_oh_s),
    .idx (wrap_idx_s)
  );

  // Requesters above the pointer win first; otherwise wrap to the LSB side.
  always_comb begin
    if (|cand_s) begin
      win_oh_s  = cand_oh_s;
      win_idx_s = cand_idx_s;
    end else begin
      win_oh_s  = wrap_oh_s;
      win_idx_s = wrap_idx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT, LOCKED: begin
        if (!bus.i_ack) begin
          state_nxt_s = state_r;
        end else if (LOCK && !bus.i_last) begin
          state_nxt_s = LOCKED;
        end else if (|req_s) begin
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: next grant, index and pointer.
  always_comb begin
    gnt_nxt_s = gnt_r;
    idx_nxt_s = idx_r;
    ptr_nxt_s = ptr_r;
    case (state_r)
      IDLE: begin
        gnt_nxt_s = win_oh_s;
        idx_nxt_s = win_idx_s;
      end
      GRANT, LOCKED: begin
        if (bus.i_ack && (!LOCK || bus.i_last)) begin
          ptr_nxt_s = gnt_r;
          gnt_nxt_s = win_oh_s;
          idx_nxt_s = win_idx_s;
        end else begin
          gnt_nxt_s = gnt_r;
          idx_nxt_s = idx_r;
          ptr_nxt_s = ptr_r;
        end
      end
      default: begin
        gnt_nxt_s = {W{1'b0}};
        idx_nxt_s = {IDX_W{1'b0}};
        ptr_nxt_s = PTR_RST;
      end
    endcase
  end

  // Grant, index, valid and pointer registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      gnt_r <= {W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
      vld_r <= 1'b0;
      ptr_r <= PTR_RST;
    end else begin
      gnt_r <= gnt_nxt_s;
      idx_r <= idx_nxt_s;
      vld_r <= |gnt_nxt_s;
      ptr_r <= ptr_nxt_s;
    end
  end

  assign bus.o_gnt     = gnt_r;
  assign bus.o_gnt_vld = vld_r;
  assign bus.o_gnt_idx = idx_r;

`ifdef MASK_RR_ARB_PERF_EN
  logic [CNT_W-1:0] cnt_r [W];

  // Saturating count of accepted beats per requester.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < W; k++) begin
        cnt_r[k] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < W; k++) begin
        if (bus.i_ack && vld_r && gnt_r[k] && (cnt_r[k] != {CNT_W{1'b1}})) begin
          cnt_r[k] <= cnt_r[k] + CNT_W'(1'b1);
        end
      end
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_cnt
    assign bus.o_gnt_cnt[g*CNT_W +: CNT_W] = cnt_r[g];
  end
`endif

  mask_rr_arb_chk #(.W(W)) u_chk (
    .clk     (clk),
    .arst_n  (arst_n),
    .req     (bus.i_req),
    .gnt     (gnt_r),
    .gnt_vld (vld_r)
  );

endmodule

// File: tb/tb_mask_rr_arb.sv
// Self-checking bench for mask_rr_arb: two W=4 instances (LOCK=0, LOCK=1).
// Counter checks run when MASK_RR_ARB_PERF_EN is defined.
module tb_mask_rr_arb;

  logic clk;
  logic arst_n;
  int   n_chk;
  int   n_pass;

  mask_rr_arb_if #(.W(4), .CNT_W(2)) if0 ();
  mask_rr_arb_if #(.W(4), .CNT_W(2)) if1 ();

  mask_rr_arb #(.W(4), .LOCK(1'b0), .CNT_W(2)) u_dut0 (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (if0)
  );

  mask_rr_arb #(.W(4), .LOCK(1'b1), .CNT_W(2)) u_dut1 (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (if1)
  );

  typedef struct {
    bit         sel;
    logic [3:0] req;
    logic       ack;
    logic       last;
    logic [3:0] gnt;
    logic [1:0] idx;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] idx;
    string      name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input bit sel, input logic [3:0] req, input logic ack,
                              input logic last, input logic [3:0] gnt,
                              input logic [1:0] idx, input string name);
    vec_t v;
    v.sel = sel; v.req = req; v.ack = ack; v.last = last;
    v.gnt = gnt; v.idx = idx; v.name = name;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the selected instance, queue the expected
  // registered result, then compare it one edge later.
  task automatic apply(input bit sel, input logic [3:0] req, input logic ack,
                       input logic last, input logic [3:0] egnt,
                       input logic [1:0] eidx, input string nm);
    exp_t e;
    logic [6:0] act;
    if (sel) begin
      if1.i_req = req; if1.i_ack = ack; if1.i_last = last;
      if0.i_req = 4'b0000; if0.i_ack = 1'b0; if0.i_last = 1'b0;
    end else begin
      if0.i_req = req; if0.i_ack = ack; if0.i_last = last;
      if1.i_req = 4'b0000; if1.i_ack = 1'b0; if1.i_last = 1'b0;
    end
    e.gnt = egnt; e.vld = (egnt != 4'b0000); e.idx = eidx; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    act = sel ? {if1.o_gnt, if1.o_gnt_vld, if1.o_gnt_idx}
              : {if0.o_gnt, if0.o_gnt_vld, if0.o_gnt_idx};
    chk(e.name, 64'(act), 64'({e.gnt, e.vld, e.idx}));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    arst_n = 1'b0;
    if0.i_req = 4'b0000; if0.i_ack = 1'b0; if0.i_last = 1'b0;
    if1.i_req = 4'b0000; if1.i_ack = 1'b0; if1.i_last = 1'b0;

    // rotation, wrap from pointer 3, sole-requester bubble, idle ack (LOCK=0)
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, "rot0"));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1, "rot1"));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2, "rot2"));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3, "rot3"));
    tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0, "rot_wrap"));
    tbl.push_back(mk(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, "rot_drain"));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, "idle0"));
    tbl.push_back(mk(1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3, "mk_ptr3"));
    tbl.push_back(mk(1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000, 2'd0, "ptr3_rel"));
    tbl.push_back(mk(1'b0, 4'b1001, 1'b0, 1'b0, 4'b0001, 2'd0, "wrap_lsb"));
    tbl.push_back(mk(1'b0, 4'b1001, 1'b1, 1'b0, 4'b1000, 2'd3, "after_wrap"));
    tbl.push_back(mk(1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000, 2'd0, "drain2"));
    tbl.push_back(mk(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, "sole_gnt"));
    tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0, "sole_bubble"));
    tbl.push_back(mk(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, "sole_regnt"));
    tbl.push_back(mk(1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 2'd0, "sole_rel"));
    tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, "ack_idle_ignored"));
    tbl.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, "idle_ack_gnt"));
    tbl.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 2'd0, "drain4"));
    // packet lock on requester 1, then hand-over to 2 (LOCK=1)
    tbl.push_back(mk(1'b1, 4'b0110, 1'b0, 1'b0, 4'b0010, 2'd1, "lk_gnt"));
    tbl.push_back(mk(1'b1, 4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1, "lk_beat1"));
    tbl.push_back(mk(1'b1, 4'b0110, 1'b0, 1'b0, 4'b0010, 2'd1, "lk_wait"));
    tbl.push_back(mk(1'b1, 4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1, "lk_beat2"));
    tbl.push_back(mk(1'b1, 4'b0110, 1'b1, 1'b1, 4'b0100, 2'd2, "lk_last"));
    tbl.push_back(mk(1'b1, 4'b0100, 1'b1, 1'b1, 4'b0000, 2'd0, "lk_drain"));

    #12;
    chk("rst_out0", 64'({if0.o_gnt, if0.o_gnt_vld, if0.o_gnt_idx}), 64'(0));
    chk("rst_out1", 64'({if1.o_gnt, if1.o_gnt_vld, if1.o_gnt_idx}), 64'(0));
`ifdef MASK_RR_ARB_PERF_EN
    chk("rst_cnt0", 64'(if0.o_gnt_cnt), 64'(0));
`endif
    #10;
    arst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].sel, tbl[i].req, tbl[i].ack, tbl[i].last,
            tbl[i].gnt, tbl[i].idx, tbl[i].name);
    end

    // async reset while LOCKED on requester 1
    apply(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1, "pre_rst_gnt");
    apply(1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, "pre_rst_lock");
    #2;
    arst_n = 1'b0;
    #1;
    chk("async_clr", 64'({if1.o_gnt, if1.o_gnt_vld, if1.o_gnt_idx}), 64'(0));
    @(posedge clk);
    #1;
    chk("in_reset", 64'({if1.o_gnt, if1.o_gnt_vld}), 64'(0));
    if1.i_ack = 1'b0;
    #2;
    arst_n = 1'b1;
    apply(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0010, 2'd1, "post_rst_gnt");
    apply(1'b1, 4'b0010, 1'b1, 1'b1, 4'b0000, 2'd0, "post_rst_drain");

`ifdef MASK_RR_ARB_PERF_EN
    #2;
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    apply(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, "perf_idle_ack");
    chk("perf_cnt_idle", 64'(if0.o_gnt_cnt), 64'(0));
    apply(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, "perf_gnt");
    for (int k = 1; k <= 5; k++) begin
      apply(1'b0, 4'b0001, 1'b1, 1'b0, 4'b0000, 2'd0, "perf_ack");
      chk("perf_cnt0", 64'(if0.o_gnt_cnt[1:0]), 64'((k > 3) ? 3 : k));
      chk("perf_cnt_oth", 64'(if0.o_gnt_cnt[7:2]), 64'(0));
      apply(1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, "perf_regnt");
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mask_rr_arb.md
Name: mask_rr_arb

Overview:
- Registered round-robin arbiter across W requesters with a valid/ack grant handshake.
- Priority rotation uses a unary mask derived from the one-hot last-winner pointer: requesters strictly above the last winner (toward MSB) win first, then wrap to the LSB.
- Optional per-requester packet lock holds the grant across multi-beat transfers.
- Sits in front of shared resources (ports, buffers, buses) in common/.

Parameters:
- W, 8, number of requesters; legal range 1..64.
- LOCK, 1'b1, when 1 a grant persists across beats until i_last is accepted; when 0 every accepted beat re-arbitrates.
- CNT_W, 16, width of each grant counter (used only with MASK_RR_ARB_PERF_EN).

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- i_req  in  W  per-requester request; must be held until its grant is acked.
- i_last  in  1  final beat of the current transfer; sampled only with i_ack.
- i_ack  in  1  downstream accepts the current grant beat.
- o_gnt  out  W  registered one-hot grant.
- o_gnt_vld  out  1  o_gnt is valid (equals |o_gnt).
- o_gnt_idx  out  $clog2(W) (min 1)  binary index of o_gnt; 0 when !o_gnt_vld.
- o_gnt_cnt  out  W*CNT_W  per-requester accepted-grant counters; present only with MASK_RR_ARB_PERF_EN.

Behaviour:
- Reset (async assert, sync deassert handled upstream): o_gnt=0, o_gnt_vld=0, o_gnt_idx=0, ptr=one-hot bit W-1, FSM=IDLE, counters=0.
- ptr is the one-hot register of the last winner. Mask m[j]=|ptr[j-1:0] (bits strictly above ptr set).
- Selection: cand = i_req & m. If cand != 0, the winner is the lowest set bit of cand; otherwise it is the lowest set bit of i_req (wrap-around).
- FSM IDLE: when i_req != 0, register the winner into o_gnt, set o_gnt_vld, and go to GRANT. Latency is 1 cycle from request to grant.
- FSM GRANT: hold o_gnt while !i_ack. On i_ack:
  - If LOCK and !i_last: go to LOCKED; o_gnt is unchanged; ptr is not updated.
  - Otherwise: ptr<=o_gnt, then re-arbitrate in the same cycle using the updated mask and the current i_req excluding the acked requester's bit. If another requester wins, it is granted next cycle with no bubble. If none wins, go to IDLE with o_gnt=0.
- FSM LOCKED: identical to GRANT, except other requesters are never considered until i_ack && i_last.
- The acked requester may win again only when it is the sole requester. In that case its bit is re-admitted the following cycle, giving one bubble.
- Dropping i_req while granted is a protocol violation. The grant is retained, and an assertion fires under simulation.
- W==1: the mask is always 0. Grant whenever i_req[0]=1; ptr has no effect.
- i_ack while !o_gnt_vld is ignored.
- arst_n asserted mid-transfer: all state clears immediately, and any lock is abandoned.

Optional Feature:
- MASK_RR_ARB_PERF_EN defined:
  - Adds o_gnt_cnt.
  - Counter k increments on each i_ack while o_gnt[k]=1.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the port and counters are absent; no other behaviour changes.

Decomposition:
- Package mask_rr_arb_pkg: FSM enum (IDLE, GRANT, LOCKED) and a function computing the index width as max(1,$clog2(W)).
- One sub-module, ffs_lsb: combinational lowest-set-bit picker with parameter W, input vector, one-hot output and binary-index output. Instantiate it twice, once for cand and once for the wrap path.

Test Plan:
- W=4, LOCK=0, i_req=4'b1111 held, i_ack=1 every cycle -> after reset o_gnt sequence is 0001,0010,0100,1000,0001 with no bubbles.
- W=4, LOCK=0, ptr=1000 (last winner 3), i_req=4'b1001 -> grant 0001 (wrap), then 1000; o_gnt_idx 0 then 3.
- W=4, LOCK=1, i_req=0110, beats with i_last=0,0,1 on requester 1 -> o_gnt=0010 held for 3 acks, then 0100.
- W=4, i_req=0100 only, ack without last under LOCK=0 -> regrant 0100 after one idle cycle (o_gnt_vld 1,0,1).
- arst_n low during LOCKED with o_gnt=0010 -> o_gnt=0 and o_gnt_vld=0 immediately; after release with i_req=0010, o_gnt=0010 one cycle later.
- MASK_RR_ARB_PERF_EN, CNT_W=2, requester 0 acked 5 times -> o_gnt_cnt[0] reads 1,2,3,3,3; other counters stay 0.
